// File: rtl/vlc_pkg.sv
// Shared types and defaults for the VLC frame packer.
package vlc_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } vlc_state_t;

   localparam int VLC_FRAME_LEN_DEFAULT = 224;
   localparam int VLC_SAMPLE_W_DEFAULT  = 16;

endpackage

// File: rtl/vlc_packer_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port.
// rd_data holds its value while rd_en is low.
module vlc_packer_ram #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/vlc_frame_packer.sv
// Collects FRAME_LEN qualified samples, then streams them out as one AXI4-Stream frame.
// Define VLC_PACKER_HDR_EN to prepend a frame-count header beat to every frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_FILL  | accepting samples into the buffer at wr_ptr
// ST_LOAD  | one cycle: synchronous read of mem[0] in flight
// ST_DRAIN | streaming buffer (and optional header) out, AXI handshaking
module vlc_frame_packer
   import vlc_pkg::*;
#(
   parameter int DATA_WIDTH = VLC_SAMPLE_W_DEFAULT,
   parameter int FRAME_LEN  = VLC_FRAME_LEN_DEFAULT,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  s_valid,
   input  logic                  s_en,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [15:0]           frame_cnt,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   vlc_state_t            state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  rd_pend;
`ifdef VLC_PACKER_HDR_EN
   logic                  hdr_pend;
`endif

   logic                  sample_in;
   logic                  accept;
   logic                  out_free;
   logic                  hdr_go;
   logic                  load_word;
   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;

   // rd_data always holds mem[rd_ptr] while rd_pend is set; the next read is
   // issued in the same cycle the current word moves into the output register.
   always_comb begin
      sample_in = s_valid && s_en;
      accept    = sample_in && (state == ST_FILL);
      out_free  = !m_axis_tvalid || m_axis_tready;
`ifdef VLC_PACKER_HDR_EN
      hdr_go    = (state == ST_DRAIN) && hdr_pend && out_free;
`else
      hdr_go    = 1'b0;
`endif
      load_word = (state == ST_DRAIN) && rd_pend && out_free && !hdr_go;
      rd_en     = 1'b0;
      rd_addr   = '0;
      if (state == ST_LOAD) begin
         rd_en = 1'b1;
      end else if (load_word && (rd_ptr != LAST_IDX)) begin
         rd_en   = 1'b1;
         rd_addr = rd_ptr + PTR_ONE;
      end
   end

   vlc_packer_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_ptr),
      .wr_data (s_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= ST_FILL;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         rd_pend       <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         frame_cnt     <= '0;
         overflow      <= 1'b0;
`ifdef VLC_PACKER_HDR_EN
         hdr_pend      <= 1'b0;
`endif
      end else begin
         if (sample_in && (state != ST_FILL)) overflow <= 1'b1;

         case (state)
            ST_FILL: begin
               if (accept) begin
                  if (wr_ptr == LAST_IDX) begin
                     wr_ptr <= '0;
                     rd_ptr <= '0;
                     state  <= ST_LOAD;
                  end else begin
                     wr_ptr <= wr_ptr + PTR_ONE;
                  end
               end
            end

            ST_LOAD: begin
               rd_pend  <= 1'b1;
`ifdef VLC_PACKER_HDR_EN
               hdr_pend <= 1'b1;
`endif
               state    <= ST_DRAIN;
            end

            ST_DRAIN: begin
               if (hdr_go) begin
                  m_axis_tdata  <= DATA_WIDTH'(frame_cnt);
                  m_axis_tlast  <= 1'b0;
                  m_axis_tvalid <= 1'b1;
`ifdef VLC_PACKER_HDR_EN
                  hdr_pend      <= 1'b0;
`endif
               end else if (load_word) begin
                  m_axis_tdata  <= rd_data;
                  m_axis_tlast  <= (rd_ptr == LAST_IDX);
                  m_axis_tvalid <= 1'b1;
                  if (rd_ptr == LAST_IDX) rd_pend <= 1'b0;
                  else                    rd_ptr  <= rd_ptr + PTR_ONE;
               end else if (m_axis_tvalid && m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  if (m_axis_tlast) begin
                     m_axis_tlast <= 1'b0;
                     frame_cnt    <= frame_cnt + 16'd1;
                     state        <= ST_FILL;
                  end
               end
            end

            default: state <= ST_FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_vlc_frame_packer.sv
// Directed bench for vlc_frame_packer: table of frame scenarios plus hand-written
// overflow and mid-frame reset sequences; honours VLC_PACKER_HDR_EN.
module tb_vlc_frame_packer;

   localparam int FRAME_LEN = 224;
`ifdef VLC_PACKER_HDR_EN
   localparam int NBEATS = FRAME_LEN + 1;
`else
   localparam int NBEATS = FRAME_LEN;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        s_valid;
   logic        s_en;
   logic [15:0] s_data;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;
   logic [15:0] frame_cnt;
   logic        overflow;

   vlc_frame_packer dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_valid       (s_valid),
      .s_en          (s_en),
      .s_data        (s_data),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .frame_cnt     (frame_cnt),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   int          rmode = 0;   // 0: tready=1, 1: random, 2: tready=0
   logic [16:0] got_q[$];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Output monitor: drives tready, records beats, checks AXI hold during stalls.
   initial begin
      logic        prev_stall;
      logic [15:0] prev_data;
      logic        prev_last;
      prev_stall    = 1'b0;
      prev_data     = '0;
      prev_last     = 1'b0;
      m_axis_tready = 1'b0;
      forever begin
         @(negedge clk);
         if (prev_stall)
            chk("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_last, prev_data});
         case (rmode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
         endcase
         if (m_axis_tvalid === 1'b1 && m_axis_tready)
            got_q.push_back({m_axis_tlast, m_axis_tdata});
         prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // Drives n samples base..base+n-1; s_en strobes every period cycles with
   // s_valid held high and junk data between strobes.
   task automatic send_frame(input int base, input int n, input int period,
                             input int gap_at, input int gap_len);
      logic saw_valid;
      saw_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            repeat (gap_len) begin
               @(negedge clk);
               saw_valid |= m_axis_tvalid;
               s_valid = 1'b0; s_en = 1'b0;
            end
         end
         for (int k = 0; k < period - 1; k++) begin
            @(negedge clk);
            saw_valid |= m_axis_tvalid;
            s_valid = 1'b1; s_en = 1'b0; s_data = 16'hBEEF;
         end
         @(negedge clk);
         saw_valid |= m_axis_tvalid;
         s_valid = 1'b1; s_en = 1'b1; s_data = 16'(base + i);
      end
      @(negedge clk);
      saw_valid |= m_axis_tvalid;
      s_valid = 1'b0; s_en = 1'b0;
      chk("early_tvalid", {31'd0, saw_valid}, 32'd0);
      if (n == FRAME_LEN) begin
         @(negedge clk);
         chk("latency_cycle1", {31'd0, m_axis_tvalid}, 32'd0);
         @(negedge clk);
         chk("latency_cycle2", {31'd0, m_axis_tvalid}, 32'd1);
      end
   endtask

   task automatic check_frame(input int base, input int hdr);
      int          t;
      int          j;
      logic [16:0] exp;
      t = 0;
      while (got_q.size() < NBEATS && t < 20000) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk("beat_count", 32'(got_q.size()), 32'(NBEATS));
      for (int i = 0; i < NBEATS && i < got_q.size(); i++) begin
`ifdef VLC_PACKER_HDR_EN
         j = i - 1;
`else
         j = i;
`endif
         if (j < 0) exp = {1'b0, 16'(hdr)};
         else       exp = {(j == FRAME_LEN - 1), 16'(base + j)};
         chk("beat", {15'd0, got_q[i]}, {15'd0, exp});
      end
   endtask

   typedef struct {
      int base;
      int period;
      int gap_at;
      int gap_len;
      int rmode;
      int exp_fc;
   } vec_t;

   vec_t vecs[3];

   initial begin
      vecs[0] = '{base: 0, period: 3, gap_at: -1,  gap_len: 0,  rmode: 0, exp_fc: 1};
      vecs[1] = '{base: 0, period: 3, gap_at: -1,  gap_len: 0,  rmode: 1, exp_fc: 2};
      vecs[2] = '{base: 0, period: 1, gap_at: 101, gap_len: 50, rmode: 0, exp_fc: 3};

      resetn = 1'b0; s_valid = 1'b0; s_en = 1'b0; s_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("rst_tlast", {31'd0, m_axis_tlast}, 32'd0);
      chk("rst_tdata", {16'd0, m_axis_tdata}, 32'd0);
      chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      resetn = 1'b1;

      foreach (vecs[v]) begin
         rmode = vecs[v].rmode;
         got_q.delete();
         send_frame(vecs[v].base, FRAME_LEN, vecs[v].period, vecs[v].gap_at, vecs[v].gap_len);
         check_frame(vecs[v].base, vecs[v].exp_fc - 1);
         chk("frame_cnt", {16'd0, frame_cnt}, 32'(vecs[v].exp_fc));
         chk("overflow_clear", {31'd0, overflow}, 32'd0);
      end

      // Samples offered while the frame is stalled in DRAIN are dropped.
      rmode = 2;
      got_q.delete();
      send_frame(2000, FRAME_LEN, 1, -1, 0);
      repeat (2) begin
         @(negedge clk);
         s_valid = 1'b1; s_en = 1'b0; s_data = 16'hDEAD;
      end
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      chk("no_overflow_without_en", {31'd0, overflow}, 32'd0);
      repeat (3) begin
         @(negedge clk);
         s_valid = 1'b1; s_en = 1'b1; s_data = 16'hDEAD;
      end
      @(negedge clk);
      s_valid = 1'b0; s_en = 1'b0;
      @(negedge clk);
      chk("overflow_set", {31'd0, overflow}, 32'd1);
      rmode = 0;
      check_frame(2000, 3);
      chk("frame_cnt_ovf", {16'd0, frame_cnt}, 32'd4);

      got_q.delete();
      send_frame(3000, FRAME_LEN, 2, -1, 0);
      check_frame(3000, 4);
      chk("frame_cnt_next", {16'd0, frame_cnt}, 32'd5);
      chk("overflow_sticky", {31'd0, overflow}, 32'd1);

      // One-cycle reset partway through a fill discards the partial frame.
      got_q.delete();
      send_frame(9000, 150, 1, -1, 0);
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("midrst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("midrst_overflow", {31'd0, overflow}, 32'd0);
      send_frame(1000, FRAME_LEN, 1, -1, 0);
      check_frame(1000, 0);
      chk("frame_cnt_after_rst", {16'd0, frame_cnt}, 32'd1);
      chk("overflow_after_rst", {31'd0, overflow}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
